addsub_serial: RTL and testbench

- Parametrised sequential two's-complement adder/subtracter. It is the next generation of the team's 4-bit ripple add/sub unit.
- Operands of WIDTH bits are processed DIGIT bits per clock, so area trades against latency.
- Operands enter and results leave through valid/ready handshakes, so the block drops into the team's datapath between a producer and a consumer.
- Results carry unsigned carry/borrow, signed overflow and zero flags.

---
 rtl/addsub_pkg.sv | 18 +
 rtl/addsub_digit.sv | 23 ++
 rtl/addsub_serial.sv | 109 ++++++++++
 tb/tb_addsub_serial.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and elaboration helpers for the digit-serial add/sub unit.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// DIGIT-bit ripple-carry adder slice built from a chain of full adders.
module addsub_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co = c[DIGIT];

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial two's-complement adder/subtracter with valid/ready on both sides.
// Subtraction is A + ~B + 1: B is inverted on entry and the carry seeded with sub.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] st,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int CW   = cnt_w(NDIG);

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("addsub_serial: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, r_q, r_nxt;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, sa_q, sb_q;
  logic [DIGIT-1:0] dsum;
  logic             dco;
  logic             accept, fire, last;

  assign accept = in_valid && in_ready;
  assign fire   = out_valid && out_ready;
  assign last   = (cnt_q == CW'(NDIG - 1));

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .x  (a_q[DIGIT-1:0]),
    .y  (b_q[DIGIT-1:0]),
    .ci (carry_q),
    .s  (dsum),
    .co (dco)
  );

  // Result fills from the top so the first (least significant) digit ends up at bit 0.
  if (NDIG == 1) begin : g_one
    assign r_nxt = dsum;
  end else begin : g_shift
    assign r_nxt = {dsum, r_q[WIDTH-1:DIGIT]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last)   state_nxt = DONE;
      DONE:    if (fire)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b ^ {WIDTH{sub}};
      carry_q <= sub;
      cnt_q   <= '0;
      sa_q    <= a[WIDTH-1];
      sb_q    <= b[WIDTH-1] ^ sub;
    end else if (state == RUN) begin
      a_q     <= a_q >> DIGIT;
      b_q     <= b_q >> DIGIT;
      r_q     <= r_nxt;
      carry_q <= dco;
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  // Flags are gated by out_valid so they read 0 outside DONE, including after reset.
  assign st   = r_q;
  assign cout = out_valid & carry_q;
  assign ovf  = out_valid & (sa_q == sb_q) & (r_q[WIDTH-1] != sa_q);
  assign zero = out_valid & (r_q == '0);

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: three configurations (8/2, 16/4, 8/8) against an arithmetic model.
module tb_addsub_serial;

  typedef struct {
    logic [15:0] st;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  logic iv [3];
  logic ir [3];
  logic ov [3];
  logic ordy [3];
  logic sb [3];
  logic co [3];
  logic of [3];
  logic zr [3];
  logic [7:0]  a0, b0, a2, b2, st0, st2;
  logic [15:0] a1, b1, st1;
  logic [15:0] sto [3];

  assign sto[0] = {8'h00, st0};
  assign sto[1] = st1;
  assign sto[2] = {8'h00, st2};

  addsub_serial #(.WIDTH(8), .DIGIT(2)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a0), .b(b0), .sub(sb[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .st(st0), .cout(co[0]), .ovf(of[0]), .zero(zr[0]));

  addsub_serial #(.WIDTH(16), .DIGIT(4)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a1), .b(b1), .sub(sb[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .st(st1), .cout(co[1]), .ovf(of[1]), .zero(zr[1]));

  addsub_serial #(.WIDTH(8), .DIGIT(8)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a2), .b(b2), .sub(sb[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .st(st2), .cout(co[2]), .ovf(of[2]), .zero(zr[2]));

  function automatic int wid(input int i);
    return (i == 1) ? 16 : 8;
  endfunction

  function automatic int ndg(input int i);
    return (i == 2) ? 1 : 4;
  endfunction

  // Plain integer arithmetic: unsigned for st/cout, signed range test for ovf.
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic s);
    exp_t e;
    longint m, ua, ub, sa, sbv, r, sr;
    m   = longint'(1) << w;
    ua  = longint'(a) & (m - 1);
    ub  = longint'(b) & (m - 1);
    sa  = (ua >= m / 2) ? ua - m : ua;
    sbv = (ub >= m / 2) ? ub - m : ub;
    r   = s ? ua - ub : ua + ub;
    sr  = s ? sa - sbv : sa + sbv;
    e.st   = 16'(((r % m) + m) % m);
    e.cout = s ? (ua >= ub) : (ua + ub >= m);
    e.ovf  = (sr >= m / 2) || (sr < -(m / 2));
    e.zero = (e.st == 16'h0);
    e.acc  = 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic set_in(input int i, input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic s);
    iv[i] = v;
    sb[i] = s;
    case (i)
      0:       begin a0 = a[7:0]; b0 = b[7:0]; end
      1:       begin a1 = a;      b1 = b;      end
      default: begin a2 = a[7:0]; b2 = b[7:0]; end
    endcase
  endtask

  exp_t q [3][$];
  bit   seen [3];

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (ov[i]) begin
          if (q[i].size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL spurious_valid%0d: got out_valid=1, required 0", i);
          end else begin
            e = q[i][0];
            chk($sformatf("st%0d", i), 32'(sto[i]), 32'(e.st));
            chk($sformatf("cout%0d", i), 32'(co[i]), 32'(e.cout));
            chk($sformatf("ovf%0d", i), 32'(of[i]), 32'(e.ovf));
            chk($sformatf("zero%0d", i), 32'(zr[i]), 32'(e.zero));
            chk($sformatf("in_ready_done%0d", i), 32'(ir[i]), 32'd0);
            if (!seen[i]) begin
              chk($sformatf("latency%0d", i), 32'(cyc - e.acc), 32'(ndg(i)));
              seen[i] = 1'b1;
            end
            if (ordy[i]) begin
              void'(q[i].pop_front());
              seen[i] = 1'b0;
            end
          end
        end else if (q[i].size() != 0 && (cyc - q[i][0].acc) >= ndg(i)) begin
          vectors++;
          miscompares++;
          $display("FAIL late_valid%0d: got out_valid=0 after %0d cycles, required 1 after %0d",
                   i, cyc - q[i][0].acc, ndg(i));
          void'(q[i].pop_front());
        end
      end
    end
  end

  task automatic do_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic s,
                       input int hold, input bit poke, input bit use_lit, input exp_t lit);
    exp_t e;
    int n;
    n = 0;
    while (!ir[i] && n < 50) begin @(posedge clk); #1; n++; end
    if (!ir[i]) begin
      vectors++; miscompares++;
      $display("FAIL in_ready_timeout%0d: got in_ready=0, required 1 within 50 cycles", i);
      return;
    end
    set_in(i, 1'b1, a, b, s);
    @(posedge clk); #1;
    set_in(i, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
    e = model(wid(i), a, b, s);
    e.acc = cyc;
    q[i].push_back(e);
    n = 0;
    while (!ov[i] && n < 50) begin @(posedge clk); #1; n++; end
    if (!ov[i]) begin
      vectors++; miscompares++;
      $display("FAIL out_valid_timeout%0d: got out_valid=0, required 1 within 50 cycles", i);
      q[i].delete();
      return;
    end
    if (use_lit) begin
      chk("lit_st", 32'(sto[i]), 32'(lit.st));
      chk("lit_cout", 32'(co[i]), 32'(lit.cout));
      chk("lit_ovf", 32'(of[i]), 32'(lit.ovf));
      chk("lit_zero", 32'(zr[i]), 32'(lit.zero));
    end
    for (int h = 0; h < hold; h++) begin
      if (poke && h == 0) set_in(i, 1'b1, 16'h1, 16'h1, 1'b0);
      @(posedge clk); #1;
      set_in(i, 1'b0, 16'h0, 16'h0, 1'b0);
    end
    ordy[i] = 1'b1;
    @(posedge clk); #1;
    ordy[i] = 1'b0;
  endtask

  // Directed op: pin the model against hand-computed values, then run it on the DUT.
  task automatic dir(input int i, input logic [15:0] a, input logic [15:0] b, input logic s,
                     input int hold, input bit poke, input logic [15:0] l_st, input logic l_co,
                     input logic l_ov, input logic l_z);
    exp_t m, lit;
    lit.st = l_st; lit.cout = l_co; lit.ovf = l_ov; lit.zero = l_z; lit.acc = 0;
    m = model(wid(i), a, b, s);
    chk("model_pin", {m.st, 13'h0, m.cout, m.ovf, m.zero}, {l_st, 13'h0, l_co, l_ov, l_z});
    do_op(i, a, b, s, hold, poke, 1'b1, lit);
  endtask

  function automatic logic [15:0] rnd(input int w);
    logic [15:0] msk, top;
    msk = 16'((32'd1 << w) - 1);
    top = 16'(32'd1 << (w - 1));
    case ($urandom % 6)
      0:       return 16'h0;
      1:       return msk;
      2:       return top;
      3:       return top - 16'h1;
      default: return 16'($urandom) & msk;
    endcase
  endfunction

  exp_t nolit;

  initial begin
    nolit = '{st: 16'h0, cout: 1'b0, ovf: 1'b0, zero: 1'b0, acc: 0};
    for (int i = 0; i < 3; i++) begin
      set_in(i, 1'b0, 16'h0, 16'h0, 1'b0);
      ordy[i] = 1'b0;
      seen[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_in_ready%0d", i), 32'(ir[i]), 32'd1);
      chk($sformatf("rst_out_valid%0d", i), 32'(ov[i]), 32'd0);
      chk($sformatf("rst_out%0d", i), {sto[i], 13'h0, co[i], of[i], zr[i]}, 32'h0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    dir(0, 16'd200, 16'd100, 1'b0, 0, 1'b0, 16'd44,  1'b1, 1'b0, 1'b0);
    dir(0, 16'd3,   16'd8,   1'b1, 0, 1'b0, 16'hFB,  1'b0, 1'b0, 1'b0);
    dir(0, 16'd127, 16'd1,   1'b0, 1, 1'b0, 16'h80,  1'b0, 1'b1, 1'b0);
    dir(0, 16'h80,  16'd1,   1'b1, 0, 1'b0, 16'h7F,  1'b1, 1'b1, 1'b0);
    dir(0, 16'd5,   16'd5,   1'b1, 3, 1'b1, 16'h0,   1'b1, 1'b0, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    chk("poke_ignored_valid", 32'(ov[0]), 32'd0);
    chk("poke_ignored_ready", 32'(ir[0]), 32'd1);

    // Reset while the third digit is in flight; the operation must vanish.
    set_in(0, 1'b1, 16'hFF, 16'hFF, 1'b0);
    @(posedge clk); #1;
    set_in(0, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("run_in_ready", 32'(ir[0]), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(ov[0]), 32'd0);
    chk("midrst_in_ready", 32'(ir[0]), 32'd1);
    chk("midrst_out", {sto[0], 13'h0, co[0], of[0], zr[0]}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("postrst_in_ready", 32'(ir[0]), 32'd1);
    dir(0, 16'd9, 16'd6, 1'b0, 0, 1'b0, 16'd15, 1'b0, 1'b0, 1'b0);

    dir(1, 16'h7FFF, 16'h0001, 1'b0, 0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    dir(2, 16'd0,    16'd1,    1'b1, 0, 1'b0, 16'hFF,   1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 150; k++)
      do_op(1, rnd(16), rnd(16), 1'($urandom), int'($urandom_range(0, 2)), 1'b0, 1'b0, nolit);
    for (int k = 0; k < 150; k++)
      do_op(2, rnd(8), rnd(8), 1'($urandom), int'($urandom_range(0, 2)), 1'b0, 1'b0, nolit);
    for (int k = 0; k < 80; k++)
      do_op(0, rnd(8), rnd(8), 1'($urandom), int'($urandom_range(0, 2)), 1'b0, 1'b0, nolit);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
